// File: rtl/clock_edge_generator_if.sv
// Control/status bundle between rate tracking (master) and the clock edge generator (slave).
interface clock_edge_generator_if #(
  parameter int W = 16
);
  logic         clk_en_i;
  logic         generation_en_i;
  logic         clear_state_i;
  logic [W-1:0] target_i;
  logic         pause_req_i;
  logic [W-1:0] counter_current_o;
  logic         unpaused_clk_o;
  logic         unpaused_rise_o;
  logic         unpaused_fall_o;
  logic         any_valid_edge_o;
  logic         gated_clk_o;
  logic         gated_rise_o;
  logic         gated_fall_o;
  logic         paused_o;

  modport master (
    output clk_en_i, generation_en_i, clear_state_i, target_i, pause_req_i,
    input  counter_current_o, unpaused_clk_o, unpaused_rise_o, unpaused_fall_o,
           any_valid_edge_o, gated_clk_o, gated_rise_o, gated_fall_o, paused_o
  );

  modport slave (
    input  clk_en_i, generation_en_i, clear_state_i, target_i, pause_req_i,
    output counter_current_o, unpaused_clk_o, unpaused_rise_o, unpaused_fall_o,
           any_valid_edge_o, gated_clk_o, gated_rise_o, gated_fall_o, paused_o
  );
endinterface

// File: rtl/clock_edge_generator.sv
// Free-running rate counter, half-period compare, generated clock plus a glitch-free
// pausable copy that only ever stops in its low phase.
module clock_edge_generator #(
  parameter int RATE_COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     async_rst,
  clock_edge_generator_if.slave    bus
);
  localparam int W = RATE_COUNTER_WIDTH;

  typedef enum logic [1:0] {
    S_RUN,
    S_PAUSE_PEND,
    S_PAUSED,
    S_RESUME_PEND
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_cnt;
  logic           r_uclk;
  logic           r_gclk;

  logic w_clr, w_adv, w_match, w_rise, w_fall, w_grise, w_gfall, w_req;

  assign w_req   = bus.pause_req_i;
  assign w_clr   = bus.clk_en_i & bus.clear_state_i;
  assign w_adv   = bus.clk_en_i & bus.generation_en_i & ~bus.clear_state_i;
  // Pure equality keeps the compare correct across counter wrap.
  assign w_match = w_adv & (r_cnt == bus.target_i);
  assign w_rise  = w_match & ~r_uclk;
  assign w_fall  = w_match &  r_uclk;

  always_comb begin
    w_state_nxt = r_state;
    w_grise     = w_rise;
    w_gfall     = w_fall;
    case (r_state)
      S_RUN: begin
        if (w_adv && w_req) begin
          if (!r_gclk || w_fall) begin
            w_state_nxt = S_PAUSED;
            w_grise     = 1'b0;
          end else begin
            w_state_nxt = S_PAUSE_PEND;
          end
        end
      end
      S_PAUSE_PEND: begin
        if (w_adv) begin
          if (!w_req)      w_state_nxt = S_RUN;
          else if (w_fall) w_state_nxt = S_PAUSED;
        end
      end
      S_PAUSED: begin
        w_grise = 1'b0;
        w_gfall = 1'b0;
        if (w_adv && !w_req) w_state_nxt = S_RESUME_PEND;
      end
      S_RESUME_PEND: begin
        w_grise = 1'b0;
        w_gfall = 1'b0;
        if (w_adv) begin
          if (w_req) begin
            w_state_nxt = S_PAUSED;
          end else if (w_rise) begin
            w_state_nxt = S_RUN;
            w_grise     = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
    if (w_clr) w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_cnt   <= '0;
      r_uclk  <= 1'b0;
      r_gclk  <= 1'b0;
      r_state <= S_RUN;
    end else if (w_clr) begin
      r_cnt   <= '0;
      r_uclk  <= 1'b0;
      r_gclk  <= 1'b0;
      r_state <= S_RUN;
    end else begin
      if (w_adv)        r_cnt  <= r_cnt + W'(1);
      if (w_match)      r_uclk <= ~r_uclk;
      if (w_grise)      r_gclk <= 1'b1;
      else if (w_gfall) r_gclk <= 1'b0;
      r_state <= w_state_nxt;
    end
  end

  // Registers clear asynchronously but target_i may not, so gate the comb events too.
  assign bus.counter_current_o = r_cnt;
  assign bus.unpaused_clk_o    = r_uclk;
  assign bus.unpaused_rise_o   = w_rise & ~async_rst;
  assign bus.unpaused_fall_o   = w_fall & ~async_rst;
  assign bus.any_valid_edge_o  = (w_rise | w_fall) & ~async_rst;
  assign bus.gated_clk_o       = r_gclk;
  assign bus.gated_rise_o      = w_grise & ~async_rst;
  assign bus.gated_fall_o      = w_gfall & ~async_rst;
  assign bus.paused_o          = (r_state == S_PAUSED);
endmodule

// File: tb/tb_clock_edge_generator.sv
// Scoreboarded bench: the bench acts as rate tracking and predicts edges from a
// phase-length countdown, independent of the DUT's counter/target compare.
module tb_clock_edge_generator;
  localparam int W = 4;

  logic clk = 1'b0;
  logic async_rst;

  clock_edge_generator_if #(.W(W)) bus ();

  clock_edge_generator #(.RATE_COUNTER_WIDTH(W)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic [7:0]   flags;
  } exp_t;

  exp_t sbq[$];

  int n_chk = 0;
  int n_err = 0;

  // stimulus
  logic en, gen, clr, req;
  int   hi, lo;

  // model state
  logic [W-1:0] m_cnt, m_target;
  logic         m_clk, m_g;
  int           m_left, m_st;  // m_st: 0 run, 1 pause-pend, 2 paused, 3 resume-pend

  int  cyc_n;
  int  last_rise;
  bit  per_on;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_flags();
    return {bus.unpaused_clk_o, bus.unpaused_rise_o, bus.unpaused_fall_o, bus.any_valid_edge_o,
            bus.gated_clk_o, bus.gated_rise_o, bus.gated_fall_o, bus.paused_o};
  endfunction

  task automatic model_reset();
    m_cnt = '0; m_target = '0; m_clk = 1'b0; m_g = 1'b0; m_left = 0; m_st = 0;
  endtask

  task automatic cyc();
    exp_t e;
    logic adv, match, r, f, gr, gf;
    int   nst, rate;
    @(negedge clk);
    bus.clk_en_i        = en;
    bus.generation_en_i = gen;
    bus.clear_state_i   = clr;
    bus.pause_req_i     = req;
    bus.target_i        = m_target;
    adv   = en & gen & ~clr;
    match = adv && (m_left == 0);
    r = match & ~m_clk;
    f = match &  m_clk;
    gr = r; gf = f; nst = m_st;
    if (m_st == 0 && adv && req) begin
      if (!m_g || f) begin nst = 2; gr = 1'b0; end
      else nst = 1;
    end
    if (m_st == 1 && adv) nst = !req ? 0 : (f ? 2 : 1);
    if (m_st == 2) begin
      gr = 1'b0; gf = 1'b0;
      if (adv && !req) nst = 3;
    end
    if (m_st == 3) begin
      gr = 1'b0; gf = 1'b0;
      if (adv && req) nst = 2;
      else if (r) begin nst = 0; gr = 1'b1; end
    end
    e.cnt   = m_cnt;
    e.flags = {m_clk, r, f, r | f, m_g, gr, gf, (m_st == 2)};
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    chk("cnt", 32'(bus.counter_current_o), 32'(e.cnt));
    chk("flags", 32'(dut_flags()), 32'(e.flags));
    if (bus.unpaused_rise_o) begin
      if (per_on && last_rise >= 0) chk("period", cyc_n - last_rise, hi + lo);
      last_rise = cyc_n;
    end
    cyc_n++;
    if (en && clr) begin
      model_reset();
    end else begin
      if (match) begin
        rate     = r ? hi : lo;
        m_target = W'(rate + int'(m_cnt));
        m_clk    = ~m_clk;
        m_left   = rate - 1;
      end else if (adv) begin
        m_left--;
      end
      if (adv) m_cnt = m_cnt + W'(1);
      if (gr)      m_g = 1'b1;
      else if (gf) m_g = 1'b0;
      m_st = nst;
    end
  endtask

  task automatic arst_pulse();
    @(negedge clk);
    bus.clk_en_i = 1'b0;
    bus.target_i = '0;
    #2 async_rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(bus.counter_current_o), 0);
    chk("arst_flags", 32'(dut_flags()), 0);
    async_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int i;
    en = 0; gen = 0; clr = 0; req = 0; hi = 3; lo = 5;
    cyc_n = 0; last_rise = -1; per_on = 1'b1;
    model_reset();
    async_rst = 1'b1;
    bus.clk_en_i = 1'b1; bus.generation_en_i = 1'b1; bus.clear_state_i = 1'b0;
    bus.pause_req_i = 1'b0; bus.target_i = '0;
    #12;
    chk("rst_cnt", 32'(bus.counter_current_o), 0);
    chk("rst_flags", 32'(dut_flags()), 0);
    @(negedge clk);
    bus.clk_en_i = 1'b0;
    #1 async_rst = 1'b0;

    // high 3 / low 5
    en = 1; gen = 1;
    repeat (40) cyc();

    // high 5 / low 7: counter wraps many times
    hi = 5; lo = 7; last_rise = -1;
    repeat (60) cyc();
    per_on = 1'b0;

    // pause mid-high phase
    i = 0;
    while (!(m_clk && m_g && m_left >= 1) && i < 40) begin cyc(); i++; end
    if (i >= 40) chk("wait_high", 0, 1);
    req = 1;
    repeat (20) cyc();
    chk("paused", 32'(bus.paused_o), 1);
    chk("gated_low", 32'(bus.gated_clk_o), 0);

    // release mid-high phase
    i = 0;
    while (!(m_clk && m_left >= 1) && i < 40) begin cyc(); i++; end
    if (i >= 40) chk("wait_high2", 0, 1);
    req = 0;
    repeat (20) cyc();
    chk("unpaused", 32'(bus.paused_o), 0);

    // pause request in low phase, then toggle through resume-pending back to paused
    i = 0;
    while (!(!m_clk && m_left >= 3) && i < 40) begin cyc(); i++; end
    if (i >= 40) chk("wait_low", 0, 1);
    req = 1; cyc();
    req = 0; cyc();
    req = 1; cyc();
    req = 0;
    repeat (20) cyc();

    // clear in a match cycle
    i = 0;
    while (m_left != 0 && i < 40) begin cyc(); i++; end
    if (i >= 40) chk("wait_match", 0, 1);
    clr = 1; cyc();
    clr = 0; cyc();
    chk("clr_rise", 32'(bus.unpaused_rise_o), 1);
    repeat (10) cyc();

    // async reset while both clocks high
    i = 0;
    while (!(m_clk && m_g) && i < 40) begin cyc(); i++; end
    if (i >= 40) chk("wait_both_high", 0, 1);
    arst_pulse();
    repeat (15) cyc();

    // global enable and generation enable low: everything frozen
    en = 0; repeat (4) cyc();
    en = 1; gen = 0; repeat (3) cyc();
    gen = 1; repeat (15) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
